// File: rtl/memory_copier_v2.sv
// EEPROM-to-RAM block copier with optional read-back verify.
// Shares one data bus; all strobes are active-low and registered.
module memory_copier_v2 #(
  parameter int unsigned COPY_WIDTH    = 13,
  parameter logic [15:0] DEST_BASE     = 16'hE000,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned WE_CYCLES     = 1,
  parameter bit          VERIFY        = 1'b1,
  parameter bit          AUTO_START    = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  data_in,
  output logic [15:0] address,
  output logic        ram_cs_n,
  output logic        ram_we_n,
  output logic        ram_oe_n,
  output logic        eeprom_cs_n,
  output logic        eeprom_oe_n,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] error_address
);

  localparam int unsigned CMAX =
    (SETTLE_CYCLES > WE_CYCLES) ? SETTLE_CYCLES : WE_CYCLES;
  localparam int unsigned CW = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] S_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] W_LAST  = CW'(WE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [COPY_WIDTH-1:0] OFF_ONE = COPY_WIDTH'(1);

  // 17-bit shift keeps COPY_WIDTH=16 from collapsing the mask to zero
  localparam logic [15:0] OFF_MASK =
    16'((17'd1 << COPY_WIDTH) - 17'd1);
  localparam logic [15:0] BASE = DEST_BASE & ~OFF_MASK;

  typedef enum logic [3:0] {
    IDLE,
    C_SETTLE,
    C_WRITE,
    C_NEXT,
    V_ROM,
    V_RAM,
    V_NEXT,
    DONE,
    ERROR
  } state_t;

  state_t                st;
  state_t                nxt_st;
  logic [COPY_WIDTH-1:0] off;
  logic [COPY_WIDTH-1:0] nxt_off;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         nxt_cnt;
  logic [7:0]            exp_q;
  logic [7:0]            nxt_exp;
  logic [15:0]           nxt_ea;
  logic                  arm;
  logic                  last;

  assign address = BASE | 16'(off);
  assign last    = (off == '1);

  // {eeprom_cs_n, eeprom_oe_n, ram_cs_n, ram_oe_n, ram_we_n}
  function automatic logic [4:0] strb(input state_t s);
    case (s)
      C_SETTLE: strb = 5'b00011;
      C_WRITE:  strb = 5'b00010;
      C_NEXT:   strb = 5'b00011;
      V_ROM:    strb = 5'b00111;
      V_RAM:    strb = 5'b11001;
      default:  strb = 5'b11111;
    endcase
  endfunction

  function automatic logic is_busy(input state_t s);
    is_busy = !(s == IDLE || s == DONE || s == ERROR);
  endfunction

  always_comb begin
    nxt_st  = st;
    nxt_off = off;
    nxt_cnt = cnt;
    nxt_exp = exp_q;
    nxt_ea  = error_address;
    unique case (st)
      IDLE: begin
        if (start || (AUTO_START && arm)) begin
          nxt_off = '0;
          nxt_cnt = '0;
          nxt_st  = C_SETTLE;
        end
      end
      C_SETTLE: begin
        if (cnt == S_LAST) begin
          nxt_cnt = '0;
          nxt_st  = C_WRITE;
        end else begin
          nxt_cnt = cnt + CNT_ONE;
        end
      end
      C_WRITE: begin
        if (cnt == W_LAST) begin
          nxt_cnt = '0;
          nxt_st  = C_NEXT;
        end else begin
          nxt_cnt = cnt + CNT_ONE;
        end
      end
      C_NEXT: begin
        nxt_cnt = '0;
        if (last) begin
          nxt_off = '0;
          nxt_st  = VERIFY ? V_ROM : DONE;
        end else begin
          nxt_off = off + OFF_ONE;
          nxt_st  = C_SETTLE;
        end
      end
      V_ROM: begin
        if (cnt == S_LAST) begin
          nxt_cnt = '0;
          nxt_exp = data_in;
          nxt_st  = V_RAM;
        end else begin
          nxt_cnt = cnt + CNT_ONE;
        end
      end
      V_RAM: begin
        if (cnt == S_LAST) begin
          nxt_cnt = '0;
          if (data_in != exp_q) begin
            nxt_ea = address;
            nxt_st = ERROR;
          end else begin
            nxt_st = V_NEXT;
          end
        end else begin
          nxt_cnt = cnt + CNT_ONE;
        end
      end
      V_NEXT: begin
        nxt_cnt = '0;
        if (last) begin
          nxt_st = DONE;
        end else begin
          nxt_off = off + OFF_ONE;
          nxt_st  = V_ROM;
        end
      end
      DONE, ERROR: begin
        if (start) begin
          nxt_off = '0;
          nxt_cnt = '0;
          nxt_ea  = '0;
          nxt_st  = C_SETTLE;
        end
      end
    endcase
  end

  // outputs are decoded from the next state so they change with it
  always_ff @(posedge clock) begin
    if (reset) begin
      st            <= IDLE;
      off           <= '0;
      cnt           <= '0;
      exp_q         <= '0;
      arm           <= 1'b1;
      eeprom_cs_n   <= 1'b1;
      eeprom_oe_n   <= 1'b1;
      ram_cs_n      <= 1'b1;
      ram_oe_n      <= 1'b1;
      ram_we_n      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      error_address <= '0;
    end else begin
      st            <= nxt_st;
      off           <= nxt_off;
      cnt           <= nxt_cnt;
      exp_q         <= nxt_exp;
      arm           <= 1'b0;
      {eeprom_cs_n, eeprom_oe_n, ram_cs_n, ram_oe_n, ram_we_n}
                    <= strb(nxt_st);
      busy          <= is_busy(nxt_st);
      done          <= (nxt_st == DONE);
      error         <= (nxt_st == ERROR);
      error_address <= nxt_ea;
    end
  end

endmodule

// File: tb/tb_memory_copier_v2.sv
// Directed bench for memory_copier_v2: four small configurations
// share one clock, each with its own reset/start and bus model.
module tb_memory_copier_v2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // a: S=W=1, no verify, auto start
  logic        a_rst, a_start;
  logic [15:0] a_addr, a_ea;
  logic        a_rcs, a_rwe, a_roe, a_ecs, a_eoe;
  logic        a_busy, a_done, a_err;
  // b: S=2, W=3, no verify, auto start
  logic        b_rst, b_start;
  logic [15:0] b_addr, b_ea;
  logic        b_rcs, b_rwe, b_roe, b_ecs, b_eoe;
  logic        b_busy, b_done, b_err;
  // c: verify with memory model
  logic        c_rst, c_start;
  logic [15:0] c_addr, c_ea;
  logic        c_rcs, c_rwe, c_roe, c_ecs, c_eoe;
  logic        c_busy, c_done, c_err;
  logic [7:0]  c_din, rom_b;
  logic        corrupt;
  // d: no auto start, reset mid-write
  logic        d_rst, d_start;
  logic [15:0] d_addr, d_ea;
  logic        d_rcs, d_rwe, d_roe, d_ecs, d_eoe;
  logic        d_busy, d_done, d_err;

  // ROM holds 11,22,33,44; RAM mirrors it unless byte 2 is corrupted
  assign rom_b = {2'b00, c_addr[1:0], 2'b00, c_addr[1:0]} + 8'h11;
  assign c_din = !c_eoe ? rom_b :
                 !c_roe ? ((corrupt && c_addr[1:0] == 2'd2) ? 8'h5A : rom_b) :
                 8'h00;

  memory_copier_v2 #(
    .COPY_WIDTH(2), .DEST_BASE(16'hFFF0), .SETTLE_CYCLES(1),
    .WE_CYCLES(1), .VERIFY(1'b0), .AUTO_START(1'b1)
  ) u_a (
    .clock(clock), .reset(a_rst), .start(a_start), .data_in(8'h00),
    .address(a_addr), .ram_cs_n(a_rcs), .ram_we_n(a_rwe),
    .ram_oe_n(a_roe), .eeprom_cs_n(a_ecs), .eeprom_oe_n(a_eoe),
    .busy(a_busy), .done(a_done), .error(a_err), .error_address(a_ea)
  );

  memory_copier_v2 #(
    .COPY_WIDTH(2), .DEST_BASE(16'hFFF0), .SETTLE_CYCLES(2),
    .WE_CYCLES(3), .VERIFY(1'b0), .AUTO_START(1'b1)
  ) u_b (
    .clock(clock), .reset(b_rst), .start(b_start), .data_in(8'h00),
    .address(b_addr), .ram_cs_n(b_rcs), .ram_we_n(b_rwe),
    .ram_oe_n(b_roe), .eeprom_cs_n(b_ecs), .eeprom_oe_n(b_eoe),
    .busy(b_busy), .done(b_done), .error(b_err), .error_address(b_ea)
  );

  memory_copier_v2 #(
    .COPY_WIDTH(2), .DEST_BASE(16'hFFF0), .SETTLE_CYCLES(1),
    .WE_CYCLES(1), .VERIFY(1'b1), .AUTO_START(1'b1)
  ) u_c (
    .clock(clock), .reset(c_rst), .start(c_start), .data_in(c_din),
    .address(c_addr), .ram_cs_n(c_rcs), .ram_we_n(c_rwe),
    .ram_oe_n(c_roe), .eeprom_cs_n(c_ecs), .eeprom_oe_n(c_eoe),
    .busy(c_busy), .done(c_done), .error(c_err), .error_address(c_ea)
  );

  memory_copier_v2 #(
    .COPY_WIDTH(2), .DEST_BASE(16'hFFF0), .SETTLE_CYCLES(1),
    .WE_CYCLES(1), .VERIFY(1'b0), .AUTO_START(1'b0)
  ) u_d (
    .clock(clock), .reset(d_rst), .start(d_start), .data_in(8'h00),
    .address(d_addr), .ram_cs_n(d_rcs), .ram_we_n(d_rwe),
    .ram_oe_n(d_roe), .eeprom_cs_n(d_ecs), .eeprom_oe_n(d_eoe),
    .busy(d_busy), .done(d_done), .error(d_err), .error_address(d_ea)
  );

  task automatic test_reset;
    repeat (3) @(negedge clock);
    checks++;
    if ({a_ecs, a_eoe, a_rcs, a_roe, a_rwe} !== 5'b11111) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=11111",
               {a_ecs, a_eoe, a_rcs, a_roe, a_rwe});
    end
    checks++;
    if (a_addr !== 16'hFFF0) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=fff0", a_addr);
    end
    checks++;
    if ({a_busy, a_done, a_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {a_busy, a_done, a_err});
    end
    checks++;
    if (a_ea !== 16'h0000) begin
      failures++;
      $display("FAIL reset_eaddr got=%h exp=0000", a_ea);
    end
  endtask

  task automatic test_copy;
    int we_low = 0;
    logic [15:0] ea;
    logic        ew;
    a_rst = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clock);
      if (!a_rwe) we_low++;
      if (n <= 12) begin
        ea = 16'hFFF0 + 16'((n - 1) / 3);
        ew = ((n - 1) % 3) != 1;
        checks++;
        if (a_addr !== ea || a_rwe !== ew) begin
          failures++;
          $display("FAIL copy_c%0d addr/we got=%h/%b exp=%h/%b",
                   n, a_addr, a_rwe, ea, ew);
        end
        checks++;
        if ({a_rcs, a_roe, a_ecs, a_eoe, a_busy, a_done} !== 6'b010010) begin
          failures++;
          $display("FAIL copy_c%0d strb/busy/done got=%b exp=010010",
                   n, {a_rcs, a_roe, a_ecs, a_eoe, a_busy, a_done});
        end
      end else begin
        checks++;
        if ({a_done, a_busy, a_err} !== 3'b100) begin
          failures++;
          $display("FAIL copy_done_c13 got=%b exp=100",
                   {a_done, a_busy, a_err});
        end
        checks++;
        if ({a_ecs, a_eoe, a_rcs, a_roe, a_rwe} !== 5'b11111) begin
          failures++;
          $display("FAIL copy_done_strb got=%b exp=11111",
                   {a_ecs, a_eoe, a_rcs, a_roe, a_rwe});
        end
      end
    end
    checks++;
    if (we_low != 4) begin
      failures++;
      $display("FAIL copy_we_pulses got=%0d exp=4", we_low);
    end
  endtask

  task automatic test_back_to_back;
    repeat (2) @(negedge clock);
    checks++;
    if (a_done !== 1'b1) begin
      failures++;
      $display("FAIL done_hold got=%b exp=1", a_done);
    end
    a_start = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
    checks++;
    if ({a_done, a_busy, a_addr} !== {2'b01, 16'hFFF0}) begin
      failures++;
      $display("FAIL restart_c1 done/busy/addr got=%b%b/%h exp=01/fff0",
               a_done, a_busy, a_addr);
    end
    for (int n = 2; n <= 13; n++) begin
      @(negedge clock);
      a_start = (n == 5);
      if (n == 7) begin
        checks++;
        if (a_addr !== 16'hFFF2 || a_busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_start_c7 addr/busy got=%h/%b exp=fff2/1",
                   a_addr, a_busy);
        end
      end
      if (n == 12) begin
        checks++;
        if (a_done !== 1'b0 || a_addr !== 16'hFFF3) begin
          failures++;
          $display("FAIL rerun_c12 done/addr got=%b/%h exp=0/fff3",
                   a_done, a_addr);
        end
      end
      if (n == 13) begin
        checks++;
        if ({a_done, a_busy} !== 2'b10) begin
          failures++;
          $display("FAIL rerun_done_c13 got=%b exp=10", {a_done, a_busy});
        end
      end
    end
  endtask

  task automatic test_timing;
    int we_low = 0;
    int p;
    logic [15:0] ea;
    logic        ew;
    b_rst = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clock);
      if (!b_rwe) we_low++;
      if (n <= 24) begin
        p  = (n - 1) % 6;
        ea = 16'hFFF0 + 16'((n - 1) / 6);
        ew = !(p >= 2 && p <= 4);
        checks++;
        if (b_addr !== ea || b_rwe !== ew || b_busy !== 1'b1) begin
          failures++;
          $display("FAIL timing_c%0d addr/we/busy got=%h/%b/%b exp=%h/%b/1",
                   n, b_addr, b_rwe, b_busy, ea, ew);
        end
      end else begin
        checks++;
        if ({b_done, b_busy} !== 2'b10) begin
          failures++;
          $display("FAIL timing_done_c25 got=%b exp=10", {b_done, b_busy});
        end
      end
    end
    checks++;
    if (we_low != 12) begin
      failures++;
      $display("FAIL timing_we_cycles got=%0d exp=12", we_low);
    end
  endtask

  task automatic test_verify;
    int clash = 0;
    int p;
    logic [15:0] ea;
    logic [4:0]  es;
    corrupt = 1'b0;
    c_rst   = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clock);
      if ((!c_roe && !c_ecs) || (!c_roe && !c_rwe)) clash++;
      if (n >= 13 && n <= 24) begin
        p  = (n - 13) % 3;
        ea = 16'hFFF0 + 16'((n - 13) / 3);
        es = (p == 0) ? 5'b00111 : (p == 1) ? 5'b11001 : 5'b11111;
        checks++;
        if (c_addr !== ea ||
            {c_ecs, c_eoe, c_rcs, c_roe, c_rwe} !== es) begin
          failures++;
          $display("FAIL verify_c%0d addr/strb got=%h/%b exp=%h/%b",
                   n, c_addr, {c_ecs, c_eoe, c_rcs, c_roe, c_rwe}, ea, es);
        end
      end
      if (n == 25) begin
        checks++;
        if ({c_done, c_err, c_busy} !== 3'b100) begin
          failures++;
          $display("FAIL verify_done got=%b exp=100",
                   {c_done, c_err, c_busy});
        end
      end
    end
    checks++;
    if (clash != 0) begin
      failures++;
      $display("FAIL verify_bus_clash got=%0d exp=0", clash);
    end
  endtask

  task automatic test_verify_error;
    int rd3 = 0;
    corrupt = 1'b1;
    c_start = 1'b1;
    @(negedge clock);
    c_start = 1'b0;
    for (int n = 1; n <= 21; n++) begin
      if (n > 1) @(negedge clock);
      if (!c_roe && c_addr == 16'hFFF3) rd3++;
      if (n == 20) begin
        checks++;
        if (c_addr !== 16'hFFF2 || c_roe !== 1'b0) begin
          failures++;
          $display("FAIL verr_c20 addr/oe got=%h/%b exp=fff2/0",
                   c_addr, c_roe);
        end
      end
    end
    checks++;
    if ({c_err, c_done, c_busy} !== 3'b100) begin
      failures++;
      $display("FAIL verr_flags got=%b exp=100", {c_err, c_done, c_busy});
    end
    checks++;
    if (c_ea !== 16'hFFF2) begin
      failures++;
      $display("FAIL verr_eaddr got=%h exp=fff2", c_ea);
    end
    repeat (3) begin
      @(negedge clock);
      if (!c_roe && c_addr == 16'hFFF3) rd3++;
    end
    checks++;
    if (rd3 != 0) begin
      failures++;
      $display("FAIL verr_read_fff3 got=%0d exp=0", rd3);
    end
    checks++;
    if (c_err !== 1'b1 ||
        {c_ecs, c_eoe, c_rcs, c_roe, c_rwe} !== 5'b11111) begin
      failures++;
      $display("FAIL verr_hold err/strb got=%b/%b exp=1/11111",
               c_err, {c_ecs, c_eoe, c_rcs, c_roe, c_rwe});
    end
    c_start = 1'b1;
    @(negedge clock);
    c_start = 1'b0;
    checks++;
    if ({c_err, c_busy} !== 2'b01 || c_ea !== 16'h0000) begin
      failures++;
      $display("FAIL verr_restart err/busy/eaddr got=%b%b/%h exp=01/0000",
               c_err, c_busy, c_ea);
    end
    c_rst = 1'b1;
  endtask

  task automatic test_reset_mid_write;
    d_rst = 1'b0;
    repeat (5) @(negedge clock);
    checks++;
    if (d_busy !== 1'b0 || d_addr !== 16'hFFF0) begin
      failures++;
      $display("FAIL noauto_idle busy/addr got=%b/%h exp=0/fff0",
               d_busy, d_addr);
    end
    d_start = 1'b1;
    @(negedge clock);
    d_start = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (d_rwe !== 1'b0 || d_addr !== 16'hFFF1) begin
      failures++;
      $display("FAIL midwr_c5 we/addr got=%b/%h exp=0/fff1", d_rwe, d_addr);
    end
    d_rst = 1'b1;
    @(negedge clock);
    checks++;
    if ({d_ecs, d_eoe, d_rcs, d_roe, d_rwe} !== 5'b11111) begin
      failures++;
      $display("FAIL midwr_rst_strb got=%b exp=11111",
               {d_ecs, d_eoe, d_rcs, d_roe, d_rwe});
    end
    checks++;
    if ({d_busy, d_done, d_err} !== 3'b000 ||
        d_addr !== 16'hFFF0 || d_ea !== 16'h0000) begin
      failures++;
      $display("FAIL midwr_rst_state got=%b/%h/%h exp=000/fff0/0000",
               {d_busy, d_done, d_err}, d_addr, d_ea);
    end
    d_rst = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (d_busy !== 1'b0 || d_rcs !== 1'b1) begin
      failures++;
      $display("FAIL midwr_stay_idle busy/rcs got=%b/%b exp=0/1",
               d_busy, d_rcs);
    end
    d_start = 1'b1;
    @(negedge clock);
    d_start = 1'b0;
    checks++;
    if (d_busy !== 1'b1 || d_addr !== 16'hFFF0 || d_rwe !== 1'b1) begin
      failures++;
      $display("FAIL recopy_c1 busy/addr/we got=%b/%h/%b exp=1/fff0/1",
               d_busy, d_addr, d_rwe);
    end
    repeat (12) @(negedge clock);
    checks++;
    if ({d_done, d_busy} !== 2'b10) begin
      failures++;
      $display("FAIL recopy_done got=%b exp=10", {d_done, d_busy});
    end
  endtask

  initial begin
    a_rst = 1'b1; a_start = 1'b0;
    b_rst = 1'b1; b_start = 1'b0;
    c_rst = 1'b1; c_start = 1'b0;
    d_rst = 1'b1; d_start = 1'b0;
    corrupt = 1'b0;
    test_reset;
    test_copy;
    test_back_to_back;
    test_timing;
    test_verify;
    test_verify_error;
    test_reset_mid_write;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_copier_v2.md
MEMORY_COPIER_V2 -- requirements
Module: memory_copier_v2

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clock.
REQ-002 Parameter COPY_WIDTH, default 13, SHALL set the copy length to 2^COPY_WIDTH bytes.
REQ-003 Parameter DEST_BASE, default 16'hE000, SHALL give the 16-bit base address; offset bits [COPY_WIDTH-1:0] of DEST_BASE SHALL be ignored.
REQ-004 Parameter SETTLE_CYCLES, default 1, range >=1, SHALL set the address/data settle cycles per access.
REQ-005 Parameter WE_CYCLES, default 1, range >=1, SHALL set the width of the ram_we_n low pulse in cycles.
REQ-006 Parameter VERIFY, default 1, SHALL enable (1) or skip (0) the read-back compare pass.
REQ-007 Parameter AUTO_START, default 1, SHALL start a copy on the first cycle after reset deasserts without start.
REQ-008 Ports SHALL be:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle start request
- data_in  in  8  shared memory data bus
- address  out  16  DEST_BASE upper bits concatenated with offset
- ram_cs_n / ram_we_n / ram_oe_n  out  1 each  RAM strobes
- eeprom_cs_n / eeprom_oe_n  out  1 each  EEPROM strobes
- busy  out  1  transfer in progress
- done  out  1  copy (and verify) finished clean
- error  out  1  verify mismatch
- error_address  out  16  address of first mismatch

Function
REQ-009 The state machine SHALL have states IDLE, C_SETTLE, C_WRITE, C_NEXT, V_ROM, V_RAM, V_NEXT, DONE, ERROR.
REQ-010 IDLE: all strobes high; start=1 (or first post-reset cycle when AUTO_START=1) -> offset=0, C_SETTLE.
REQ-011 In C_* states, eeprom_cs_n=eeprom_oe_n=ram_cs_n=0 and ram_oe_n=1.
REQ-012 C_SETTLE SHALL last SETTLE_CYCLES cycles with ram_we_n=1, then go to C_WRITE.
REQ-013 C_WRITE SHALL last WE_CYCLES cycles with ram_we_n=0, then go to C_NEXT.
REQ-014 C_NEXT SHALL last 1 cycle with ram_we_n=1; if offset is all-ones -> offset=0 and V_ROM (VERIFY=1) or DONE (VERIFY=0); else offset+1 and C_SETTLE.
REQ-015 Copy throughput SHALL be SETTLE_CYCLES+WE_CYCLES+1 cycles per byte; address SHALL be stable across the whole per-byte sequence.
REQ-016 V_ROM: eeprom_cs_n=eeprom_oe_n=0 and ram_cs_n=1; after SETTLE_CYCLES cycles, data_in SHALL be captured as the expected byte, then go to V_RAM.
REQ-017 V_RAM: ram_cs_n=ram_oe_n=0, ram_we_n=1, and eeprom_cs_n=1; after SETTLE_CYCLES cycles, data_in SHALL be compared with the expected byte; mismatch -> error_address=address, ERROR; match -> V_NEXT.
REQ-018 V_NEXT: 1 cycle; last offset -> DONE; else offset+1 and V_ROM.
REQ-019 busy SHALL be 1 in every C_* and V_* state and 0 otherwise.
REQ-020 DONE and ERROR SHALL hold all strobes high and hold done or error respectively at 1 until a new start.
REQ-021 start while busy SHALL be ignored.
REQ-022 start in DONE or ERROR SHALL clear done, error and error_address and restart from offset 0 on the next cycle.
REQ-023 Offset SHALL never wrap past all-ones; address[15:COPY_WIDTH] SHALL equal DEST_BASE[15:COPY_WIDTH] at all times.
REQ-024 ram_we_n and ram_oe_n SHALL never be 0 in the same cycle.

Reset
REQ-025 reset=1 SHALL, on the next edge and from any state including mid-write, force IDLE, offset 0, all five strobes 1, busy=done=error=0, and error_address=0.
REQ-026 During reset, address SHALL equal DEST_BASE with the offset bits zero.

Verification
REQ-027 Use COPY_WIDTH=2, DEST_BASE=16'hFFF0, SETTLE=WE=1, VERIFY=0, AUTO_START=1; release reset -> addresses FFF0..FFF3, one ram_we_n low cycle each, 3 cycles/byte, done=1 on cycle 13, busy=0.
REQ-028 Same configuration with SETTLE_CYCLES=2 and WE_CYCLES=3 -> each byte takes 6 cycles; ram_we_n low for exactly 3 consecutive cycles per byte with address constant.
REQ-029 VERIFY=1 with a memory model returning equal ROM/RAM data -> verify visits FFF0..FFF3, ram_oe_n/eeprom_cs_n never both active, done=1, error=0.
REQ-030 VERIFY=1 with RAM byte at FFF2 corrupted to 8'h5A -> error=1, error_address=16'hFFF2, done=0, busy=0, FFF3 never read.
REQ-031 Assert reset during C_WRITE of byte 1 -> ram_we_n=1 on the next edge, all outputs at reset values; AUTO_START=0 -> block stays IDLE until start, then recopies from offset 0.
REQ-032 Pulse start while busy -> no effect; pulse start in DONE -> done drops the next cycle and a full copy repeats.
